// File: rtl/uart_receiver.sv
// 8N1 UART receiver: a two-flop synchroniser, then mid-bit sampling; no backpressure, so one-cycle valid/framing-error pulses.
// Latency: the valid pulse follows the mid-stop-bit sample by one cycle (two cycles of synchroniser delay up front).
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data_byte,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic       o_active
);

  localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_byte;
  logic [7:0]  w_byte_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        r_active;
  logic        w_active_nxt;
  logic        w_rx_s;
  logic        w_half_hit;
  logic        w_bit_hit;

  assign w_rx_s     = r_sync2;
  assign w_half_hit = (r_cnt == C_HALF);
  assign w_bit_hit  = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_sync1  <= i_rx;
      r_sync2  <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_byte   <= w_byte_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_active <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx_s) w_state_nxt = S_START;
      S_START:     if (w_half_hit) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_bit_hit && (r_idx == 3'd7)) w_state_nxt = S_STOP;
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      S_STOP:      if (w_bit_hit) w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx_s) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_byte_nxt   = r_byte;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_active_nxt = r_active;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_rx_s) w_active_nxt = 1'b1;
      end
      S_START: begin
        if (w_half_hit) begin
          w_cnt_nxt = '0;
          if (w_rx_s) w_active_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_hit) begin
          w_shift_nxt[r_idx] = w_rx_s;
          w_cnt_nxt          = '0;
          w_idx_nxt          = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_hit) begin
          w_cnt_nxt    = '0;
          w_active_nxt = 1'b0;
          if (w_rx_s) begin
            w_byte_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt    = '0;
        w_active_nxt = 1'b0;
      end
      default: begin
        w_cnt_nxt    = '0;
        w_idx_nxt    = '0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  assign o_data_byte  = r_byte;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_err;
  assign o_active     = r_active;

endmodule
